// File: rtl/counter_fifo_pkg.sv
// Shared definitions for the counter FIFO writer: FSM state encoding,
// default parameter values and a constant-width helper.
package counter_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BURST_LEN_DEF  = 16;
    localparam int GAP_CYCLES_DEF = 4;

    // Ceiling log2, used to size the word and gap counters at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_fifo_writer.sv
// Incrementing-count pattern source that writes into a FIFO in fixed-length
// bursts separated by programmable idle gaps, honouring FIFO full.
module counter_fifo_writer
    import counter_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int BCNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WE,
    output logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [BCNT_WIDTH-1:0] BURST_COUNT
);

    // Counters are at least one bit wide so BURST_LEN=1 / GAP_CYCLES<=1 still elaborate.
    localparam int WI_W = (clog2(BURST_LEN) > 0) ? clog2(BURST_LEN) : 1;
    localparam int GC_W = (clog2(GAP_CYCLES) > 0) ? clog2(GAP_CYCLES) : 1;

    localparam logic [WI_W-1:0] LAST_IDX = WI_W'(BURST_LEN - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t                state;
    logic [DATA_WIDTH-1:0] count;
    logic [WI_W-1:0]       word_idx;
    logic [GC_W-1:0]       gap_cnt;
    logic                  stop_pend;
    logic                  busy_r;
    logic                  done_r;
    logic [BCNT_WIDTH-1:0] burst_count;

    // Write strobe is combinational on FIFO_FULL so a write never hits a full FIFO.
    assign FIFO_WE     = (state == WRITE) && !FIFO_FULL;
    assign FIFO_DATA   = count;
    assign BUSY        = busy_r;
    assign DONE        = done_r;
    assign BURST_COUNT = burst_count;

    // Burst FSM with its word, gap and burst counters and the sticky stop request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            count       <= '0;
            word_idx    <= '0;
            gap_cnt     <= '0;
            stop_pend   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            burst_count <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state     <= WRITE;
                        busy_r    <= 1'b1;
                        word_idx  <= '0;
                        stop_pend <= STOP;
                    end
                end

                WRITE: begin
                    if (!FIFO_FULL) begin
                        count <= count + DATA_WIDTH'(1);
                        if (word_idx == LAST_IDX) begin
                            burst_count <= burst_count + BCNT_WIDTH'(1);
                            word_idx    <= '0;
                            if (stop_pend || STOP) begin
                                state     <= IDLE;
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                stop_pend <= 1'b0;
                            end else if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            word_idx <= word_idx + WI_W'(1);
                            if (STOP) begin
                                stop_pend <= 1'b1;
                            end
                        end
                    end else if (STOP) begin
                        stop_pend <= 1'b1;
                    end
                end

                GAP: begin
                    if (STOP) begin
                        stop_pend <= 1'b1;
                    end
                    if (gap_cnt == GAP_LAST) begin
                        state    <= WRITE;
                        word_idx <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GC_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_fifo_writer.sv
// Bench for counter_fifo_writer: two instances (wide count with gaps, narrow
// count with back-to-back bursts) driven by the same inputs and compared every
// cycle against a transaction-style reference model, plus directed checks.
module tb_counter_fifo_writer;

    localparam int BL    = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic full = 1'b0;

    logic        wa_we, wa_busy, wa_done;
    logic [31:0] wa_data;
    logic [15:0] wa_bcnt;
    logic        wb_we, wb_busy, wb_done;
    logic [3:0]  wb_data;
    logic [15:0] wb_bcnt;

    always #5 clk = ~clk;

    counter_fifo_writer #(.DATA_WIDTH(32), .BURST_LEN(BL), .GAP_CYCLES(GAP_A), .BCNT_WIDTH(16)) u_a (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .FIFO_FULL(full),
        .FIFO_WE(wa_we), .FIFO_DATA(wa_data), .BUSY(wa_busy), .DONE(wa_done), .BURST_COUNT(wa_bcnt)
    );

    counter_fifo_writer #(.DATA_WIDTH(4), .BURST_LEN(BL), .GAP_CYCLES(GAP_B), .BCNT_WIDTH(16)) u_b (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .FIFO_FULL(full),
        .FIFO_WE(wb_we), .FIFO_DATA(wb_data), .BUSY(wb_busy), .DONE(wb_done), .BURST_COUNT(wb_bcnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: running flag, gap flag, words written in this burst,
    // remaining gap cycles, pending stop, and the visible counters.
    bit          m_busy[2];
    bit          m_gap[2];
    int          m_words[2];
    int          m_gap_left[2];
    bit          m_stop[2];
    bit          m_done[2];
    logic [31:0] m_count[2];
    logic [15:0] m_bursts[2];

    // Sampled DUT outputs (taken on the falling edge).
    logic        a_we, a_busy, a_done;
    logic [31:0] a_data;
    logic [15:0] a_bcnt;
    logic        b_we, b_busy, b_done;
    logic [3:0]  b_data;
    logic [15:0] b_bcnt;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          done_cnt_a;
    logic        we_trace[16];
    logic [15:0] bcnt_trace[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        int          gapn;
        logic [31:0] mask;
        bit          stop_now;
        gapn = (i == 0) ? GAP_A : GAP_B;
        mask = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
        if (rst) begin
            m_busy[i] = 0; m_gap[i] = 0; m_words[i] = 0; m_gap_left[i] = 0;
            m_stop[i] = 0; m_done[i] = 0; m_count[i] = '0; m_bursts[i] = '0;
        end else begin
            m_done[i] = 0;
            if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i] = 1; m_gap[i] = 0; m_words[i] = 0; m_stop[i] = stop;
                end
            end else begin
                stop_now  = m_stop[i] | stop;
                m_stop[i] = stop_now;
                if (m_gap[i]) begin
                    m_gap_left[i]--;
                    if (m_gap_left[i] == 0) begin
                        m_gap[i] = 0; m_words[i] = 0;
                    end
                end else if (!full) begin
                    m_count[i] = (m_count[i] + 1) & mask;
                    m_words[i]++;
                    if (m_words[i] == BL) begin
                        m_words[i]  = 0;
                        m_bursts[i] = m_bursts[i] + 16'd1;
                        if (stop_now) begin
                            m_busy[i] = 0; m_done[i] = 1; m_stop[i] = 0;
                        end else if (gapn > 0) begin
                            m_gap[i] = 1; m_gap_left[i] = gapn;
                        end
                    end
                end
            end
        end
    endtask

    task automatic sample_and_check(input bit do_chk);
        a_we = wa_we; a_data = wa_data; a_busy = wa_busy; a_done = wa_done; a_bcnt = wa_bcnt;
        b_we = wb_we; b_data = wb_data; b_busy = wb_busy; b_done = wb_done; b_bcnt = wb_bcnt;
        if (a_we === 1'b1) qa.push_back(a_data);
        if (b_we === 1'b1) qb.push_back({28'd0, b_data});
        if (a_done === 1'b1) done_cnt_a++;
        if (do_chk) begin
            chk("a_we",   a_we,   m_busy[0] && !m_gap[0] && !full);
            chk("a_data", a_data, m_count[0]);
            chk("a_busy", a_busy, m_busy[0]);
            chk("a_done", a_done, m_done[0]);
            chk("a_bcnt", a_bcnt, m_bursts[0]);
            chk("b_we",   b_we,   m_busy[1] && !m_gap[1] && !full);
            chk("b_data", b_data, m_count[1]);
            chk("b_busy", b_busy, m_busy[1]);
            chk("b_done", b_done, m_done[1]);
            chk("b_bcnt", b_bcnt, m_bursts[1]);
        end
    endtask

    task automatic tick_c(input bit do_chk);
        @(negedge clk);
        sample_and_check(do_chk);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic tick();
        tick_c(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; full = 1'b0;
        tick();
        rst = 1'b0;
        qa.delete(); qb.delete(); done_cnt_a = 0;
    endtask

    initial begin
        bit found;
        done_cnt_a = 0;

        // Power-up reset: outputs unknown before the first edge, so not compared.
        rst = 1'b1;
        tick_c(1'b0);
        tick_c(1'b0);
        rst = 1'b0;
        tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_data", a_data, 0);
        chk("rst_bcnt", a_bcnt, 0);

        // Basic bursting with gaps on A, back-to-back on B.
        qa.delete(); qb.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i < 16) begin
                we_trace[i]   = a_we;
                bcnt_trace[i] = a_bcnt;
            end
        end
        for (int i = 0; i < 8; i++) chk("basic_data", qa[i], i);
        chk("basic_gap0", we_trace[4], 0);
        chk("basic_gap1", we_trace[5], 0);
        chk("basic_resume", we_trace[6], 1);
        chk("basic_bcnt1", bcnt_trace[4], 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (a_done === 1'b1) found = 1;
        end
        chk("basic_done_seen", found, 1);
        chk("basic_idle", a_busy, 0);

        // Back-pressure: hold at word 2 for three cycles, then finish with a stop on the last word.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", a_data, 2);
            chk("bp_hold_we", a_we, 0);
        end
        full = 1'b0;
        tick();
        chk("bp_resume_data", a_data, 2);
        chk("bp_resume_we", a_we, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("bp_last_data", a_data, 3);
        tick();
        chk("bp_done", a_done, 1);
        chk("bp_busy", a_busy, 0);
        chk("bp_nwrites", qa.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_seq", qa[i], i);

        // Stop pulsed at word 1: burst completes, then silence.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        tick();
        chk("stop_done", a_done, 1);
        chk("stop_busy", a_busy, 0);
        chk("stop_bcnt", a_bcnt, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stop_quiet_we", a_we, 0);
        end
        chk("stop_nwrites", qa.size(), 4);
        chk("stop_last", qa[qa.size()-1], 3);

        // START and STOP together: exactly one burst.
        do_reset();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("ss_nwrites", qa.size(), 4);
        chk("ss_ndone", done_cnt_a, 1);
        chk("ss_bcnt", a_bcnt, 1);

        // Narrow count wraps with continuous writes across burst boundaries.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        chk("wrap_nwrites", qb.size(), 18);
        chk("wrap_14", qb[14], 14);
        chk("wrap_15", qb[15], 15);
        chk("wrap_0",  qb[16], 0);
        chk("wrap_1",  qb[17], 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Reset at word 2 aborts the burst without DONE.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("mr_we", a_we, 0);
        chk("mr_data", a_data, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_bcnt", a_bcnt, 0);
        chk("mr_done", a_done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mr_restart_data", a_data, 0);
        chk("mr_restart_we", a_we, 1);

        // Randomized operation against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            full  = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; full = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
